pixel_loader: RTL

PIXEL_LOADER -- requirements
Module: pixel_loader

---
 rtl/mnist_pkg.sv | 14 +
 rtl/gap_timer.sv | 23 ++
 rtl/pixel_loader.sv | 90 +++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and FSM encoding for the MNIST pixel path.
// The inference controller imports the same definitions.
package mnist_pkg;
  localparam int         MNIST_NUM_PIXELS = 784;
  localparam logic [7:0] MNIST_SYNC_BYTE  = 8'hA5;
  localparam int         PIX_ADDR_W       = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_READY = 2'd3
  } ldr_state_e;
endpackage

// File: rtl/gap_timer.sv
// Saturating idle-gap counter; expired flags TIMEOUT-1 non-accept cycles since the last clear.
module gap_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_cnt <= '0;
    else if (clear)                     r_cnt <= '0;
    else if (enable && (r_cnt != LIMIT)) r_cnt <= r_cnt + CW'(1);
  end

  assign expired = (r_cnt == LIMIT);
endmodule

// File: rtl/pixel_loader.sv
// Frames a byte stream (sync byte + NUM_PIXELS pixels) into pixel RAM writes
// and holds image_ready until the consumer acknowledges the image.
module pixel_loader
  import mnist_pkg::*;
#(
  parameter int         NUM_PIXELS = MNIST_NUM_PIXELS,
  parameter logic [7:0] SYNC_BYTE  = MNIST_SYNC_BYTE,
  parameter int         TIMEOUT    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  done_ack,
  output logic                  wr_en,
  output logic [PIX_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  image_ready,
  output logic                  frame_err
);
  ldr_state_e            r_state, w_next;
  logic [PIX_ADDR_W-1:0] r_idx;
  logic [PIX_ADDR_W-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic                  r_wr_en, r_frame_err;
  logic                  w_acc, w_sync, w_last, w_load, w_expired, w_timeout;

  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_acc     = in_valid && in_ready;
  assign w_load    = (r_state == ST_LOAD);
  assign w_sync    = (r_state == ST_IDLE) && w_acc && (in_data == SYNC_BYTE);
  assign w_last    = (r_idx == PIX_ADDR_W'(NUM_PIXELS - 1));
  // An accept in the expiring cycle keeps the frame alive.
  assign w_timeout = w_load && !w_acc && w_expired;

  gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_acc || !w_load),
    .enable  (w_load && !w_acc),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_sync) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_acc && w_last) w_next = ST_FLUSH;
        else if (w_timeout)  w_next = ST_IDLE;
      end
      ST_FLUSH: w_next = ST_READY;
      ST_READY: if (done_ack) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= w_load && w_acc;
      r_frame_err <= w_timeout;
      if (w_sync || w_timeout) begin
        r_idx <= '0;
      end else if (w_load && w_acc) begin
        r_wr_addr <= r_idx;
        r_wr_data <= in_data;
        // Index parks on the last address; the next sync clears it.
        if (!w_last) r_idx <= r_idx + PIX_ADDR_W'(1);
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_err   = r_frame_err;
  assign image_ready = (r_state == ST_READY);
endmodule
